// File: rtl/poly_pkg.sv
// poly_pkg: shared types and defaults for the polynomial unit.
// Holds mode/state encodings, default widths and a rotate helper.
package poly_pkg;

    localparam int WID_D    = 12;
    localparam int LANES_D  = 4;
    localparam int ADDWID_D = 5;

    typedef enum logic [1:0] {
        M_LOAD   = 2'b00,
        M_NTT    = 2'b01,
        M_INTT   = 2'b10,
        M_UNLOAD = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UNLOAD,
        S_XRD,
        S_XDRAIN,
        S_DONE
    } state_e;

    // Width of a pass index for a given pass count (at least 1 bit).
    function automatic int pw(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

    // Rotate the low w bits of a left by n (n < w).
    function automatic logic [31:0] rotl(
        input logic [31:0] a,
        input int unsigned w,
        input int unsigned n
    );
        logic [31:0] m;
        m = (32'h1 << w) - 32'h1;
        return ((a << n) | (a >> (w - n))) & m;
    endfunction

endpackage

// File: rtl/poly_ntt_seq_if.sv
// poly_ntt_seq_if: control bundle between poly control, RAM, ROM and butterflies.
// master = poly control side (mode/run/in_valid), slave = sequencer side.
interface poly_ntt_seq_if #(
    parameter int ADDWID = poly_pkg::ADDWID_D,
    parameter int TWWID  = ADDWID + 2,
    parameter int PASSES = 4
);
    import poly_pkg::*;

    localparam int PW = pw(PASSES);

    mode_e             mode;
    logic              run;
    logic              in_valid;
    logic              in_ready;
    logic              ram_re;
    logic [ADDWID-1:0] ram_ra;
    logic              ram_we;
    logic [ADDWID-1:0] ram_wa;
    logic              ram_wsel;
    logic [TWWID-1:0]  tw_addr;
    logic              bf_mode;
    logic              out_valid;
    logic [PW-1:0]     pass_idx;
    logic              busy;
    logic              done;

    modport master (
        output mode, run, in_valid,
        input  in_ready, ram_re, ram_ra, ram_we, ram_wa, ram_wsel,
        input  tw_addr, bf_mode, out_valid, pass_idx, busy, done
    );

    modport slave (
        input  mode, run, in_valid,
        output in_ready, ram_re, ram_ra, ram_we, ram_wa, ram_wsel,
        output tw_addr, bf_mode, out_valid, pass_idx, busy, done
    );

endinterface

// File: rtl/poly_wb_delay.sv
// poly_wb_delay: LAT-deep {valid, addr} delay line for butterfly write-back.
// Ports: clk, rst (async low), in_v/in_a push, out_v/out_a retire, empty.
module poly_wb_delay #(
    parameter int AW  = 5,
    parameter int LAT = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_v,
    input  logic [AW-1:0] in_a,
    output logic          out_v,
    output logic [AW-1:0] out_a,
    output logic          empty
);

    logic [LAT-1:0] v;
    logic [AW-1:0]  a [LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v <= '0;
            a <= '{default: '0};
        end else begin
            v[0] <= in_v;
            a[0] <= in_a;
            for (int i = 1; i < LAT; i++) begin
                v[i] <= v[i-1];
                a[i] <= a[i-1];
            end
        end
    end

    assign out_v = v[LAT-1];
    assign out_a = a[LAT-1];

    // Nothing queued behind the output stage: once the entry now
    // being written retires, the line holds nothing.
    generate
        if (LAT > 1) begin : g_deep
            assign empty = ~|v[LAT-2:0];
        end else begin : g_one
            assign empty = 1'b1;
        end
    endgenerate

endmodule

// File: rtl/poly_ntt_seq.sv
// poly_ntt_seq: RAM/twiddle addressing and write-back timing for load,
// unload and multi-pass NTT/INTT. Ports: clk, rst (async low), bus (slave).
module poly_ntt_seq
    import poly_pkg::*;
#(
    parameter int          WID      = WID_D,
    parameter int          LANES    = LANES_D,
    parameter int          ADDWID   = ADDWID_D,
    parameter int          PASSES   = 4,
    parameter int unsigned ROT      = 1,
    parameter int          NTT_GAP  = 8,
    parameter int          INTT_GAP = 10,
    parameter int          PIPE_LAT = 6,
    parameter int          TWWID    = ADDWID + 2
) (
    input logic           clk,
    input logic           rst,
    poly_ntt_seq_if.slave bus
);

    localparam int DEPTH = 2 ** ADDWID;
    localparam int PW    = pw(PASSES);
    localparam int GMAX  = (NTT_GAP > INTT_GAP) ? NTT_GAP : INTT_GAP;
    localparam int GW    = $clog2(GMAX + 1);

    localparam logic [ADDWID-1:0] LAST = ADDWID'(DEPTH - 1);
    localparam logic [PW-1:0]     PLST = PW'(PASSES - 1);

    state_e            state_q, state_d;
    logic [ADDWID-1:0] cnt_q, cnt_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic [PW-1:0]     pass_q, pass_d;
    logic              bfm_q, bfm_d;
    logic              tail_q, tail_d;
    logic              ov_q;

    logic              re, ld_we, push;
    logic [ADDWID-1:0] ra, xra;
    logic [TWWID-1:0]  tw;
    logic [GW-1:0]     gap;
    int unsigned       rot_n;
    logic              wb_v, wb_empty;
    logic [ADDWID-1:0] wb_a;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            pass_q  <= '0;
            bfm_q   <= 1'b0;
            tail_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            pass_q  <= pass_d;
            bfm_q   <= bfm_d;
            tail_q  <= tail_d;
            ov_q    <= re && (state_q == S_UNLOAD);
        end
    end

    always_comb begin
        rot_n = (32'(pass_q) * ROT) % ADDWID;
        xra   = ADDWID'(rotl(32'(cnt_q), ADDWID, rot_n));
        gap   = bfm_q ? GW'(NTT_GAP - 1) : GW'(INTT_GAP - 1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        pass_d  = pass_q;
        bfm_d   = bfm_q;
        tail_d  = tail_q;
        re      = 1'b0;
        ra      = '0;
        tw      = '0;
        push    = 1'b0;
        ld_we   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    cnt_d  = '0;
                    gcnt_d = '0;
                    pass_d = '0;
                    tail_d = 1'b0;
                    bfm_d  = (bus.mode == M_NTT);
                    unique case (bus.mode)
                        M_LOAD:   state_d = S_LOAD;
                        M_UNLOAD: state_d = S_UNLOAD;
                        M_NTT:    state_d = S_XRD;
                        M_INTT:   state_d = S_XRD;
                    endcase
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    ld_we = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_DONE;
                end
            end
            S_UNLOAD: begin
                if (tail_q) begin
                    tail_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    re    = 1'b1;
                    ra    = cnt_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) tail_d = 1'b1;
                end
            end
            S_XRD: begin
                if (gcnt_q == '0) begin
                    re     = 1'b1;
                    ra     = xra;
                    tw     = TWWID'({pass_q, cnt_q});
                    push   = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    gcnt_d = gap;
                    if (cnt_q == LAST) state_d = S_XDRAIN;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            S_XDRAIN: begin
                if (wb_empty) begin
                    if (pass_q == PLST) begin
                        state_d = S_DONE;
                    end else begin
                        pass_d  = pass_q + 1'b1;
                        cnt_d   = '0;
                        gcnt_d  = '0;
                        state_d = S_XRD;
                    end
                end
            end
            S_DONE: begin
                bfm_d   = 1'b0;
                pass_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    poly_wb_delay #(
        .AW  (ADDWID),
        .LAT (PIPE_LAT)
    ) u_wb (
        .clk   (clk),
        .rst   (rst),
        .in_v  (push),
        .in_a  (ra),
        .out_v (wb_v),
        .out_a (wb_a),
        .empty (wb_empty)
    );

    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.ram_re    = re;
    assign bus.ram_ra    = ra;
    assign bus.ram_we    = ld_we | wb_v;
    assign bus.ram_wa    = ld_we ? cnt_q : wb_a;
    assign bus.ram_wsel  = wb_v;
    assign bus.tw_addr   = tw;
    assign bus.bf_mode   = bfm_q;
    assign bus.out_valid = ov_q;
    assign bus.pass_idx  = pass_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_poly_ntt_seq.sv
// tb_poly_ntt_seq: directed bench for the poly_ntt_seq sequencer.
// Records RAM/ROM strobes per cycle and compares against hand-derived tables.
module tb_poly_ntt_seq;
    import poly_pkg::*;

    localparam int AW     = 5;
    localparam int DEPTH  = 32;
    localparam int PASSES = 4;
    localparam int NG     = 8;
    localparam int IG     = 10;
    localparam int LAT    = 6;

    typedef struct {
        int c;
        int a;
        int t;
        int p;
    } ev_t;

    typedef struct {
        int p;
        int c;
        int ra;
        int tw;
    } rot_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   bf_bad = 0;
    logic exp_bfm = 1'b0;

    ev_t  re_q[$];
    ev_t  we_q[$];
    int   done_q[$];
    int   ov_q[$];

    poly_ntt_seq_if #(.ADDWID(AW), .TWWID(AW + 2), .PASSES(PASSES)) bus ();

    poly_ntt_seq #(
        .WID(12), .LANES(4), .ADDWID(AW), .PASSES(PASSES), .ROT(1),
        .NTT_GAP(NG), .INTT_GAP(IG), .PIPE_LAT(LAT), .TWWID(AW + 2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        ev_t e;
        if (bus.ram_re) begin
            e.c = cyc; e.a = int'(bus.ram_ra);
            e.t = int'(bus.tw_addr); e.p = int'(bus.pass_idx);
            re_q.push_back(e);
        end
        if (bus.ram_we) begin
            e.c = cyc; e.a = int'(bus.ram_wa);
            e.t = int'(bus.ram_wsel); e.p = 0;
            we_q.push_back(e);
        end
        if (bus.done) done_q.push_back(cyc);
        if (bus.out_valid) ov_q.push_back(cyc);
        if (bus.busy && bus.bf_mode != exp_bfm) bf_bad++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        re_q.delete();
        we_q.delete();
        done_q.delete();
        ov_q.delete();
        bf_bad = 0;
    endtask

    task automatic start(input mode_e m);
        bus.mode = m;
        bus.run  = 1'b1;
        @(posedge clk); #1;
        bus.run  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({nm, "_done_seen"}, int'(done_q.size() != 0), 1);
    endtask

    task automatic chk_idle_outs(input string nm);
        chk({nm, "_ctl"}, int'({bus.ram_re, bus.ram_we, bus.ram_wsel,
            bus.in_ready, bus.out_valid, bus.busy, bus.done, bus.bf_mode}), 0);
        chk({nm, "_addr"}, int'(bus.ram_ra) + int'(bus.ram_wa) +
            int'(bus.tw_addr) + int'(bus.pass_idx), 0);
    endtask

    task automatic chk_xform(input string nm, input int gap, input int dtot);
        int bad_gap = 0;
        int bad_pass = 0;
        int bad_wb = 0;
        int r0;
        int w0;
        for (int i = 1; i < re_q.size(); i++) begin
            int exp_d;
            exp_d = (i % DEPTH == 0) ? LAT + 1 : gap;
            if (re_q[i].c - re_q[i-1].c != exp_d) bad_gap++;
        end
        for (int i = 0; i < re_q.size(); i++)
            if (re_q[i].p != i / DEPTH) bad_pass++;
        for (int i = 0; i < we_q.size() && i < re_q.size(); i++)
            if (we_q[i].c != re_q[i].c + LAT || we_q[i].a != re_q[i].a ||
                we_q[i].t != 1) bad_wb++;
        r0 = (re_q.size() > 0) ? re_q[0].c : -1000;
        w0 = (we_q.size() > 0) ? we_q[0].c : -1000;
        chk({nm, "_reads"}, re_q.size(), DEPTH * PASSES);
        chk({nm, "_writes"}, we_q.size(), DEPTH * PASSES);
        chk({nm, "_read_spacing"}, bad_gap, 0);
        chk({nm, "_pass_idx"}, bad_pass, 0);
        chk({nm, "_wb_match"}, bad_wb, 0);
        chk({nm, "_first_we_lat"}, w0 - r0, LAT);
        chk({nm, "_done_time"}, (done_q.size() > 0) ? done_q[0] - r0 : -1, dtot);
        chk({nm, "_done_count"}, done_q.size(), 1);
        chk({nm, "_bf_mode"}, bf_bad, 0);
    endtask

    initial begin
        rot_vec_t vt[10];
        int n;
        int nwe;
        int bad;

        vt[0] = '{0, 0, 0, 0};
        vt[1] = '{0, 5, 5, 5};
        vt[2] = '{1, 1, 2, 33};
        vt[3] = '{1, 31, 31, 63};
        vt[4] = '{2, 1, 4, 65};
        vt[5] = '{2, 3, 12, 67};
        vt[6] = '{2, 16, 2, 80};
        vt[7] = '{3, 1, 8, 97};
        vt[8] = '{3, 3, 24, 99};
        vt[9] = '{3, 17, 12, 113};

        bus.mode     = M_LOAD;
        bus.run      = 1'b0;
        bus.in_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_idle_outs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // Load with three idle gaps.
        clr();
        exp_bfm = 1'b0;
        start(M_LOAD);
        chk("load_in_ready", int'(bus.in_ready), 1);
        for (int w = 0; w < DEPTH; w++) begin
            if (w == 5 || w == 12 || w == 20) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        wait_done(10, "load");
        repeat (3) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < we_q.size(); i++)
            if (we_q[i].a != i || we_q[i].t != 0) bad++;
        chk("load_writes", we_q.size(), DEPTH);
        chk("load_order_wsel", bad, 0);
        chk("load_done_time", (done_q.size() > 0 && we_q.size() > 0) ?
            done_q[0] - we_q[we_q.size()-1].c : -1, 1);
        chk("load_done_count", done_q.size(), 1);
        chk("load_busy_after", int'(bus.busy), 0);
        chk("load_in_ready_after", int'(bus.in_ready), 0);

        // NTT with a run pulse mid-transform that must be ignored.
        clr();
        exp_bfm = 1'b1;
        start(M_NTT);
        repeat (300) @(posedge clk);
        #1;
        bus.run = 1'b1;
        @(posedge clk); #1;
        bus.run = 1'b0;
        wait_done(1100, "ntt");
        repeat (20) @(posedge clk);
        #1;
        chk_xform("ntt", NG, PASSES * ((DEPTH - 1) * NG + LAT + 1));
        chk("ntt_busy_after", int'(bus.busy), 0);

        // INTT: rotation table, hazard between passes.
        clr();
        exp_bfm = 1'b0;
        start(M_INTT);
        wait_done(1400, "intt");
        repeat (5) @(posedge clk);
        #1;
        chk_xform("intt", IG, PASSES * ((DEPTH - 1) * IG + LAT + 1));
        for (int k = 0; k < 10; k++) begin
            int idx;
            idx = vt[k].p * DEPTH + vt[k].c;
            chk($sformatf("intt_ra_p%0d_c%0d", vt[k].p, vt[k].c),
                (idx < re_q.size()) ? re_q[idx].a : -1, vt[k].ra);
            chk($sformatf("intt_tw_p%0d_c%0d", vt[k].p, vt[k].c),
                (idx < re_q.size()) ? re_q[idx].t : -1, vt[k].tw);
        end
        chk("intt_no_overlap",
            (re_q.size() > 64 && we_q.size() > 63) ?
            int'(re_q[64].c > we_q[63].c) : 0, 1);

        // Unload.
        clr();
        exp_bfm = 1'b0;
        start(M_UNLOAD);
        wait_done(60, "unload");
        repeat (3) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < re_q.size(); i++)
            if (re_q[i].a != i || (i > 0 && re_q[i].c != re_q[i-1].c + 1)) bad++;
        chk("unload_reads", re_q.size(), DEPTH);
        chk("unload_addr_seq", bad, 0);
        bad = 0;
        for (int i = 0; i < ov_q.size() && i < re_q.size(); i++)
            if (ov_q[i] != re_q[i].c + 1) bad++;
        chk("unload_out_valid_count", ov_q.size(), DEPTH);
        chk("unload_out_valid_lag", bad, 0);
        chk("unload_done_time", (done_q.size() > 0 && re_q.size() > 0) ?
            done_q[0] - re_q[re_q.size()-1].c : -1, 2);
        chk("unload_no_writes", we_q.size(), 0);

        // Reset in the middle of pass 1.
        clr();
        exp_bfm = 1'b1;
        start(M_NTT);
        n = 0;
        while (re_q.size() < DEPTH + 11 && n < 600) begin
            @(posedge clk);
            n++;
        end
        chk("abort_reach_p1c10", int'(re_q.size() >= DEPTH + 11), 1);
        chk("abort_ra_p1c10", (re_q.size() > 42) ? re_q[42].a : -1, 20);
        #1;
        rst = 1'b0;
        #1;
        chk_idle_outs("abort");
        nwe = we_q.size();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_we", we_q.size() - nwe, 0);
        clr();
        start(M_NTT);
        n = 0;
        while (re_q.size() == 0 && n < 5) begin
            @(posedge clk);
            n++;
        end
        chk("restart_seen", int'(re_q.size() > 0), 1);
        chk("restart_state", (re_q.size() > 0) ?
            re_q[0].p + re_q[0].a + re_q[0].t : -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
